mac_tx_fcs_ctrl: RTL

Transmit-side sequencer that drives the byte-wide CRC-32 LFSR (`mac_lfsr`) for every outgoing Ethernet frame. It accepts a byte stream of destination MAC through payload, pads short frames to the minimum length, and appends the 4-byte FCS. It then holds off the next frame for the inter-frame gap. It sits between the TX frame builder and the GMII/RGMII TX adapter.

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_lfsr.sv | 50 +++++
 rtl/mac_tx_fcs_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared MAC constants and the TX FCS sequencer state type.
package mac_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam int          ETH_MIN_FRAME = 60;
   localparam int          ETH_IFG       = 12;

   typedef enum logic [2:0] {
      IDLE,
      PAYLOAD,
      PAD,
      FCS,
      IFG
   } fcs_state_t;

endpackage

// File: rtl/mac_lfsr.sv
// Byte-wide Galois LFSR for CRC generation; lfsr_state_out includes the current data_in when data_valid_in is high.
module mac_lfsr #(
   parameter int                    LFSR_WIDTH = 32,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04C11DB7,
   parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = '1,
   parameter bit                    REVERSE    = 1'b1,
   parameter int                    DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid_in,
   output logic [LFSR_WIDTH-1:0] lfsr_state_out
);

   function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
      logic [LFSR_WIDTH-1:0] r;
      for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
      return r;
   endfunction

   localparam logic [LFSR_WIDTH-1:0] POLY_REV = reflect(LFSR_POLY);

   logic [LFSR_WIDTH-1:0] state_q;
   logic [LFSR_WIDTH-1:0] state_d;

   // Reflected mode shifts right and consumes data LSB first (Ethernet bit order).
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      if (data_valid_in) begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            if (REVERSE)
               state_d = (state_d >> 1) ^ ({LFSR_WIDTH{state_d[0] ^ data_in[i]}} & POLY_REV);
            else
               state_d = (state_d << 1) ^
                         ({LFSR_WIDTH{state_d[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i]}} & LFSR_POLY);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) state_q <= LFSR_INIT;
      else     state_q <= state_d;
   end

   assign lfsr_state_out = state_d;

endmodule

// File: rtl/mac_tx_fcs_ctrl.sv
// Ethernet TX sequencer: passes payload, pads to minimum length, appends CRC-32 FCS, then enforces the IFG.
module mac_tx_fcs_ctrl
   import mac_pkg::*;
#(
   parameter int MIN_FRAME_LEN = ETH_MIN_FRAME,
   parameter int IFG_BYTES     = ETH_IFG,
   parameter int LEN_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [7:0]           s_tdata,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   input  logic                 s_tlast,
   input  logic                 s_tuser,
   output logic [7:0]           m_tdata,
   output logic                 m_tvalid,
   input  logic                 m_tready,
   output logic                 m_tlast,
   output logic                 m_tuser,
   output logic                 frame_done,
   output logic [LEN_WIDTH-1:0] frame_len
);

   localparam logic [LEN_WIDTH-1:0] MIN_LEN   = LEN_WIDTH'(MIN_FRAME_LEN);
   localparam int                   IFG_CNT_W = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
   // The IDLE cycle that accepts the next byte counts as the last gap cycle.
   localparam logic [IFG_CNT_W-1:0] IFG_LOAD  = IFG_CNT_W'((IFG_BYTES > 1) ? IFG_BYTES - 1 : 0);

   fcs_state_t           state, state_next;
   logic                 load, accept, data_load, fcs_load, fcs_cap, fcs_done, lfsr_rst;
   logic [LEN_WIDTH-1:0] len_cnt, len_new;
   logic [LEN_WIDTH:0]   len_sum;
   logic [31:0]          fcs_reg, lfsr_state;
   logic [1:0]           fcs_idx;
   logic [IFG_CNT_W-1:0] ifg_cnt;
   logic                 abort;

   assign load     = !m_tvalid || m_tready;
   assign s_tready = !rst && load && (state == IDLE || state == PAYLOAD);
   assign accept   = s_tvalid && s_tready;
   assign fcs_done = (state == FCS) && m_tvalid && m_tready && m_tlast;
   assign lfsr_rst = rst || fcs_done;
   assign len_sum  = {1'b0, len_cnt} + (LEN_WIDTH+1)'(4);

   always_comb begin
      len_new = (&len_cnt) ? len_cnt : len_cnt + 1'b1;
      if (state == IDLE) len_new = LEN_WIDTH'(1);
   end

   always_comb begin
      state_next = state;
      data_load  = 1'b0;
      fcs_load   = 1'b0;
      fcs_cap    = 1'b0;
      case (state)
         IDLE, PAYLOAD: begin
            if (accept) begin
               data_load  = 1'b1;
               state_next = PAYLOAD;
               if (s_tlast) begin
                  if (len_new < MIN_LEN) begin
                     state_next = PAD;
                  end else begin
                     state_next = FCS;
                     fcs_cap    = 1'b1;
                  end
               end
            end
         end
         PAD: begin
            if (load) begin
               data_load = 1'b1;
               if (len_new >= MIN_LEN) begin
                  state_next = FCS;
                  fcs_cap    = 1'b1;
               end
            end
         end
         FCS: begin
            fcs_load = load && !(m_tvalid && m_tlast);
            if (fcs_done) state_next = (IFG_BYTES > 1) ? IFG : IDLE;
         end
         IFG: begin
            if (ifg_cnt <= IFG_CNT_W'(1)) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         m_tdata    <= '0;
         m_tvalid   <= 1'b0;
         m_tlast    <= 1'b0;
         m_tuser    <= 1'b0;
         frame_done <= 1'b0;
         frame_len  <= '0;
         len_cnt    <= '0;
         fcs_reg    <= '0;
         fcs_idx    <= '0;
         ifg_cnt    <= '0;
         abort      <= 1'b0;
      end else begin
         state      <= state_next;
         frame_done <= fcs_done;
         if (fcs_done) frame_len <= len_sum[LEN_WIDTH] ? '1 : len_sum[LEN_WIDTH-1:0];
         if (data_load) len_cnt <= len_new;
         if (accept && s_tlast) abort <= s_tuser;
         if (fcs_done) ifg_cnt <= IFG_LOAD;
         else if (state == IFG) ifg_cnt <= ifg_cnt - 1'b1;
         if (fcs_cap) begin
            fcs_reg <= ~lfsr_state;
            fcs_idx <= '0;
         end

         // Output register: m_* only change on a load, so stalls keep them stable.
         if (data_load) begin
            m_tdata  <= (state == PAD) ? 8'h00 : s_tdata;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
         end else if (fcs_load) begin
            m_tdata  <= fcs_reg[{fcs_idx, 3'b000} +: 8];
            m_tvalid <= 1'b1;
            m_tlast  <= (fcs_idx == 2'd3);
            m_tuser  <= (fcs_idx == 2'd3) && abort;
            fcs_idx  <= fcs_idx + 1'b1;
         end else if (load) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= 1'b0;
         end
      end
   end

   mac_lfsr #(
      .LFSR_WIDTH (32),
      .LFSR_POLY  (CRC32_POLY),
      .LFSR_INIT  (CRC32_INIT),
      .REVERSE    (1'b1),
      .DATA_WIDTH (8)
   ) u_lfsr (
      .clk            (clk),
      .rst            (lfsr_rst),
      .data_in        ((state == PAD) ? 8'h00 : s_tdata),
      .data_valid_in  (data_load),
      .lfsr_state_out (lfsr_state)
   );

endmodule
